// File: rtl/logic_cone_sweeper.sv
// Exhaustive self-test sequencer for the 6-input logic cone: sweeps all 64 vectors and checks y against a golden model.
// Optional build macro CONE_STOP_ON_FAIL_EN ends the sweep on the first mismatch.
module logic_cone_sweeper #(
    parameter int SETTLE = 3,
    parameter int ERR_W  = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             y_in,
    output logic [5:0]       vec,
    output logic             exp_y,
    output logic             busy,
    output logic             done,
    output logic [ERR_W-1:0] err_cnt,
    output logic [5:0]       first_fail_vec,
    output logic             first_fail_valid
);

    // state | meaning
    // IDLE  | waiting for start; results from the last sweep held
    // RUN   | driving vec, settling cnt clocks, comparing y_in on the last one

    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;

    logic a, b, c, d, e, f;
    logic t1, t2, t3;
    logic compare_edge;
    logic mismatch;
    logic last_vec;
    logic sweep_end;

    assign {a, b, c, d, e, f} = vec;

    // Golden cone: t2 is structurally constant 0, so exp_y is 1 for every vector.
    assign t1    = ~(a & b);
    assign t2    = c & ~d & d;
    assign t3    = ~(e | f);
    assign exp_y = ~(t1 & t2 & t3);

    assign compare_edge = (cnt == CNT_LAST);
    assign mismatch     = (y_in != exp_y);
    assign last_vec     = (vec == 6'd63);

`ifdef CONE_STOP_ON_FAIL_EN
    assign sweep_end = last_vec | mismatch;
`else
    assign sweep_end = last_vec;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            cnt              <= '0;
            vec              <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            err_cnt          <= '0;
            first_fail_vec   <= '0;
            first_fail_valid <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        state            <= RUN;
                        busy             <= 1'b1;
                        vec              <= '0;
                        cnt              <= '0;
                        err_cnt          <= '0;
                        first_fail_vec   <= '0;
                        first_fail_valid <= 1'b0;
                    end
                end
                RUN: begin
                    // abort wins over the compare that would fall on the same edge
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        vec   <= '0;
                        cnt   <= '0;
                    end else if (compare_edge) begin
                        if (mismatch) begin
                            if (err_cnt != {ERR_W{1'b1}}) begin
                                err_cnt <= err_cnt + ERR_W'(1);
                            end
                            if (!first_fail_valid) begin
                                first_fail_vec   <= vec;
                                first_fail_valid <= 1'b1;
                            end
                        end
                        cnt <= '0;
                        if (sweep_end) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            vec   <= '0;
                        end else begin
                            vec <= vec + 6'd1;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    vec   <= '0;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_logic_cone_sweeper.sv
// Directed bench for logic_cone_sweeper with SETTLE=3, ERR_W=7.
module tb_logic_cone_sweeper;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic       y_in;
    logic [5:0] vec;
    logic       exp_y;
    logic       busy;
    logic       done;
    logic [6:0] err_cnt;
    logic [5:0] first_fail_vec;
    logic       first_fail_valid;

    int checks = 0;
    int errors = 0;
    int n;

    logic_cone_sweeper #(.SETTLE(3), .ERR_W(7)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .abort            (abort),
        .y_in             (y_in),
        .vec              (vec),
        .exp_y            (exp_y),
        .busy             (busy),
        .done             (done),
        .err_cnt          (err_cnt),
        .first_fail_vec   (first_fail_vec),
        .first_fail_valid (first_fail_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // y pattern: 0 const 1, 1 low at vec 5, 2 const 0
    task automatic set_y(input int mode);
        case (mode)
            0: y_in = 1'b1;
            1: y_in = (vec == 6'd5) ? 1'b0 : 1'b1;
            default: y_in = 1'b0;
        endcase
    endtask

    task automatic accept();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Called right after the accept edge; returns edges until done is seen.
    task automatic sweep_wait(input int mode, input bit repulse, output int cnt_edges);
        cnt_edges = 0;
        set_y(mode);
        while (!done && cnt_edges < 400) begin
            chk("vec_seq", 32'(vec), 32'(cnt_edges / 3));
            chk("exp_y", 32'(exp_y), 32'd1);
            chk("busy_run", 32'(busy), 32'd1);
            start = (repulse && (cnt_edges == 10 || cnt_edges == 100)) ? 1'b1 : 1'b0;
            tick();
            start = 1'b0;
            cnt_edges++;
            set_y(mode);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        y_in  = 1'b1;
        #2;
        chk("rst_vec", 32'(vec), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err_cnt), 32'd0);
        chk("rst_ffv", 32'(first_fail_valid), 32'd0);
        chk("rst_ffvec", 32'(first_fail_vec), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // 1: clean sweep
        accept();
        sweep_wait(0, 1'b0, n);
        chk("t1_len", 32'(n), 32'd192);
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_busy", 32'(busy), 32'd0);
        chk("t1_vec", 32'(vec), 32'd0);
        chk("t1_err", 32'(err_cnt), 32'd0);
        chk("t1_ffv", 32'(first_fail_valid), 32'd0);
        // start while done is high is accepted
        accept();
        chk("t1_done_fall", 32'(done), 32'd0);
        chk("t1_restart_busy", 32'(busy), 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t1_abort_busy", 32'(busy), 32'd0);

        // 2: single failure at vec 5
        accept();
        sweep_wait(1, 1'b0, n);
`ifdef CONE_STOP_ON_FAIL_EN
        chk("t2_len", 32'(n), 32'd18);
`else
        chk("t2_len", 32'(n), 32'd192);
`endif
        chk("t2_err", 32'(err_cnt), 32'd1);
        chk("t2_ffvec", 32'(first_fail_vec), 32'd5);
        chk("t2_ffv", 32'(first_fail_valid), 32'd1);
        tick();
        chk("t2_done_fall", 32'(done), 32'd0);
        chk("t2_err_hold", 32'(err_cnt), 32'd1);

        // 3: every vector fails
        accept();
        sweep_wait(2, 1'b0, n);
`ifdef CONE_STOP_ON_FAIL_EN
        chk("t3_len", 32'(n), 32'd3);
        chk("t3_err", 32'(err_cnt), 32'd1);
`else
        chk("t3_len", 32'(n), 32'd192);
        chk("t3_err", 32'(err_cnt), 32'd64);
`endif
        chk("t3_ffvec", 32'(first_fail_vec), 32'd0);
        chk("t3_ffv", 32'(first_fail_valid), 32'd1);

        // 4: abort on the compare edge of vec 10 (that compare would mismatch)
        accept();
        n = 0;
        while (vec != 6'd10 && n < 100) begin
`ifdef CONE_STOP_ON_FAIL_EN
            y_in = 1'b1;
`else
            y_in = (vec == 6'd3) ? 1'b0 : 1'b1;
`endif
            tick();
            n++;
        end
        chk("t4_reach10", 32'(n), 32'd30);
        y_in = 1'b0;
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        y_in = 1'b1;
        chk("t4_busy", 32'(busy), 32'd0);
        chk("t4_vec", 32'(vec), 32'd0);
        chk("t4_done", 32'(done), 32'd0);
`ifdef CONE_STOP_ON_FAIL_EN
        chk("t4_err", 32'(err_cnt), 32'd0);
        chk("t4_ffv", 32'(first_fail_valid), 32'd0);
`else
        chk("t4_err", 32'(err_cnt), 32'd1);
        chk("t4_ffvec", 32'(first_fail_vec), 32'd3);
`endif
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t4_no_done", 32'(done), 32'd0);
            chk("t4_idle", 32'(busy), 32'd0);
        end
        accept();
        chk("t4_err_clr", 32'(err_cnt), 32'd0);
        chk("t4_ffv_clr", 32'(first_fail_valid), 32'd0);
        sweep_wait(0, 1'b0, n);
        chk("t4_len", 32'(n), 32'd192);
        chk("t4_err_end", 32'(err_cnt), 32'd0);

        // 5: async reset mid-sweep, between edges
        accept();
        y_in = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_vec", 32'(vec), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_done", 32'(done), 32'd0);
        chk("t5_err", 32'(err_cnt), 32'd0);
        chk("t5_ffv", 32'(first_fail_valid), 32'd0);
        chk("t5_ffvec", 32'(first_fail_vec), 32'd0);
        y_in = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();
        chk("t5_idle_busy", 32'(busy), 32'd0);
        chk("t5_idle_vec", 32'(vec), 32'd0);

        // 6: start re-pulsed while busy is ignored
        accept();
        sweep_wait(0, 1'b1, n);
        chk("t6_len", 32'(n), 32'd192);
        chk("t6_done", 32'(done), 32'd1);
        tick();
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("t6_blocked", 32'(busy), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t6_stay_idle", 32'(busy), 32'd0);
            chk("t6_vec0", 32'(vec), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
